// File: rtl/dot_product_ctrl.sv
// dot_product_ctrl: sequencer for the dot-product datapath.
// Walks memories A and B through VETOR_WIDTH consecutive addresses.
// Both memories have a one-cycle registered read.
// Accumulates a_data*b_data and offers the sum on a valid/ready port.
// Optional feature macro: DOTP_BASE_ADDR_EN. When it is defined, the
// base_addr port exists and sets the first read address, wrapping past
// the top of memory. When it is undefined, reads start at address 0.
module dot_product_ctrl #(
   parameter int DATA_WIDTH  = 8,
   parameter int VETOR_WIDTH = 4,
   parameter int DEPTH       = VETOR_WIDTH * DATA_WIDTH,
   parameter int ADDR_WIDTH  = $clog2(DEPTH),
   parameter int ACC_WIDTH   = 2 * DATA_WIDTH + $clog2(VETOR_WIDTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   output logic                  busy,
   output logic                  rd_en,
   output logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic [DATA_WIDTH-1:0] a_data,
   input  logic [DATA_WIDTH-1:0] b_data,
   output logic [ACC_WIDTH-1:0]  result,
   output logic                  result_valid,
   input  logic                  result_ready
`ifdef DOTP_BASE_ADDR_EN
   ,
   input  logic [ADDR_WIDTH-1:0] base_addr
`endif
);

   localparam int CNT_W = (VETOR_WIDTH > 1) ? $clog2(VETOR_WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(VETOR_WIDTH - 1);

   typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  rd_en_q, rd_en_d;
   logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
   logic                  rd_vld_q, rd_vld_d;   // rd_en delayed to line up with returning data
   logic [ACC_WIDTH-1:0]  acc_q, acc_d;
   logic                  res_vld_q, res_vld_d;
   logic                  busy_q, busy_d;
   logic [ADDR_WIDTH-1:0] base;
   logic [ACC_WIDTH-1:0]  prod;

`ifdef DOTP_BASE_ADDR_EN
   assign base = base_addr;
`else
   assign base = '0;
`endif

   // The product is computed at full accumulator width, so it can never overflow.
   assign prod = ACC_WIDTH'(a_data) * ACC_WIDTH'(b_data);

   // This block computes the next state, the read sequencing and the accumulation.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rd_en_d   = rd_en_q;
      rd_addr_d = rd_addr_q;
      rd_vld_d  = rd_en_q;
      acc_d     = acc_q;
      res_vld_d = res_vld_q;
      if (rd_vld_q) acc_d = acc_q + prod;
      case (state_q)
         IDLE: if (start) begin
            state_d   = READ;
            cnt_d     = '0;
            rd_en_d   = 1'b1;
            rd_addr_d = base;
            acc_d     = '0;
            rd_vld_d  = 1'b0;
         end
         READ: if (cnt_q == LAST) begin
            state_d = DRAIN;
            rd_en_d = 1'b0;
         end else begin
            cnt_d     = cnt_q + CNT_W'(1);
            rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);   // modulo 2^ADDR_WIDTH
         end
         DRAIN: begin
            // The last element pair is added at the end of this cycle.
            state_d   = DONE;
            res_vld_d = 1'b1;
         end
         DONE: if (result_ready) begin
            state_d   = IDLE;
            res_vld_d = 1'b0;
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   // These are the state and registered-output flops. Reset discards any operation in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         rd_en_q   <= 1'b0;
         rd_addr_q <= '0;
         rd_vld_q  <= 1'b0;
         acc_q     <= '0;
         res_vld_q <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rd_en_q   <= rd_en_d;
         rd_addr_q <= rd_addr_d;
         rd_vld_q  <= rd_vld_d;
         acc_q     <= acc_d;
         res_vld_q <= res_vld_d;
         busy_q    <= busy_d;
      end
   end

   assign busy         = busy_q;
   assign rd_en        = rd_en_q;
   assign rd_addr      = rd_addr_q;
   assign result       = acc_q;
   assign result_valid = res_vld_q;

endmodule

// File: tb/tb_dot_product_ctrl.sv
// Directed testbench for dot_product_ctrl. It includes registered-read models of memories A and B.
module tb_dot_product_ctrl;
   localparam int DW = 8;
   localparam int N  = 4;
   localparam int DEPTH = N * DW;
   localparam int AW = $clog2(DEPTH);
   localparam int ACCW = 2 * DW + $clog2(N);

   logic            clk = 1'b0;
   logic            rst, start, result_ready;
   logic            busy, rd_en, result_valid;
   logic [AW-1:0]   rd_addr, base_addr;
   logic [DW-1:0]   a_data, b_data;
   logic [ACCW-1:0] result;
   logic [DW-1:0]   mem_a [DEPTH];
   logic [DW-1:0]   mem_b [DEPTH];
   int              rd_cnt = 0;
   int              n_tests = 0;
   int              n_fail = 0;
   int              snap;

   always #5 clk = ~clk;

   dot_product_ctrl #(.DATA_WIDTH(DW), .VETOR_WIDTH(N)) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .rd_en(rd_en),
      .rd_addr(rd_addr), .a_data(a_data), .b_data(b_data), .result(result),
      .result_valid(result_valid), .result_ready(result_ready)
`ifdef DOTP_BASE_ADDR_EN
      , .base_addr(base_addr)
`endif
   );

   // These are the registered-read memories, each with one cycle of latency.
   always @(posedge clk) begin
      if (rd_en) begin
         a_data <= mem_a[rd_addr];
         b_data <= mem_b[rd_addr];
         rd_cnt <= rd_cnt + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic load(input int base, input int a0, a1, a2, a3, b0, b1, b2, b3);
      mem_a[(base+0)%DEPTH] = DW'(a0); mem_b[(base+0)%DEPTH] = DW'(b0);
      mem_a[(base+1)%DEPTH] = DW'(a1); mem_b[(base+1)%DEPTH] = DW'(b1);
      mem_a[(base+2)%DEPTH] = DW'(a2); mem_b[(base+2)%DEPTH] = DW'(b2);
      mem_a[(base+3)%DEPTH] = DW'(a3); mem_b[(base+3)%DEPTH] = DW'(b3);
   endtask

   // This task runs one complete dot product with result_ready held high.
   task automatic run_full(input string tag, input int exp);
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (5) tick();
      chk({tag, "_valid"}, 32'(result_valid), 1);
      chk({tag, "_result"}, 32'(result), 32'(exp));
      tick();
      chk({tag, "_busy_low"}, 32'(busy), 0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; result_ready = 1'b1; base_addr = '0;
      for (int i = 0; i < DEPTH; i++) begin mem_a[i] = '0; mem_b[i] = '0; end
      @(negedge clk); @(negedge clk);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_rd_en", 32'(rd_en), 0);
      chk("rst_rd_addr", 32'(rd_addr), 0);
      chk("rst_result", 32'(result), 0);
      chk("rst_valid", 32'(result_valid), 0);
      rst = 1'b0;
      @(negedge clk);

      // The basic vector pair is A=[1,2,3,4] and B=[5,6,7,8]. The expected sum is 5+12+21+32=70.
      load(0, 1, 2, 3, 4, 5, 6, 7, 8);
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 1; c <= N; c++) begin
         chk($sformatf("t1_rd_en_c%0d", c), 32'(rd_en), 1);
         chk($sformatf("t1_addr_c%0d", c), 32'(rd_addr), 32'(c - 1));
         chk($sformatf("t1_busy_c%0d", c), 32'(busy), 1);
         tick();
      end
      chk("t1_drain_rd_en", 32'(rd_en), 0);
      chk("t1_drain_valid", 32'(result_valid), 0);
      tick();
      chk("t1_c6_valid", 32'(result_valid), 1);
      chk("t1_c6_result", 32'(result), 70);
      tick();
      chk("t1_c7_busy", 32'(busy), 0);
      chk("t1_c7_valid", 32'(result_valid), 0);

      // Every element is 255. The expected sum is 4*65025=260100, which fits without wrapping.
      load(0, 255, 255, 255, 255, 255, 255, 255, 255);
      run_full("t2_max", 260100);

      // This case applies backpressure: result_ready stays low for 10 cycles.
      load(0, 1, 2, 3, 4, 5, 6, 7, 8);
      result_ready = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (5) tick();
      for (int c = 0; c < 10; c++) begin
         chk($sformatf("t3_hold_valid_%0d", c), 32'(result_valid), 1);
         chk($sformatf("t3_hold_result_%0d", c), 32'(result), 70);
         tick();
      end
      result_ready = 1'b1;
      tick();
      chk("t3_idle_busy", 32'(busy), 0);
      chk("t3_idle_valid", 32'(result_valid), 0);
      // This second run checks that the accumulator was cleared: 8+0+5+3=16.
      load(0, 2, 0, 1, 3, 4, 9, 5, 1);
      run_full("t3_second", 16);

      // A start pulse during READ and another during DONE must both be ignored.
      load(0, 1, 2, 3, 4, 5, 6, 7, 8);
      snap = rd_cnt;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (3) tick();
      chk("t4_valid", 32'(result_valid), 1);
      chk("t4_result", 32'(result), 70);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("t4_busy_c7", 32'(busy), 0);
      tick();
      chk("t4_busy_c8", 32'(busy), 0);
      chk("t4_rd_count", 32'(rd_cnt - snap), 4);

      // Reset is asserted in cycle 3 of READ. Every output must clear without waiting for a clock edge.
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      #1;
      chk("t5_busy", 32'(busy), 0);
      chk("t5_rd_en", 32'(rd_en), 0);
      chk("t5_rd_addr", 32'(rd_addr), 0);
      chk("t5_result", 32'(result), 0);
      chk("t5_valid", 32'(result_valid), 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      run_full("t5_after", 70);

`ifdef DOTP_BASE_ADDR_EN
      // The base address is 30, so reads wrap through 30,31,0,1. Words 2 and 3 hold decoys.
      load(0, 0, 0, 100, 100, 0, 0, 100, 100);
      load(30, 1, 2, 3, 4, 5, 6, 7, 8);
      base_addr = AW'(30);
      start = 1'b1;
      tick();
      start = 1'b0;
      base_addr = '0;
      for (int c = 0; c < N; c++) begin
         chk($sformatf("t6_addr_%0d", c), 32'(rd_addr), 32'((30 + c) % DEPTH));
         tick();
      end
      tick();
      chk("t6_valid", 32'(result_valid), 1);
      chk("t6_result", 32'(result), 70);
      tick();
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
